// File: rtl/pulse_monitor_if.sv
// rtl/pulse_monitor_if.sv - pulse monitor signal bundle
// The master side drives the pulse/err/clr inputs; the slave side is the monitor.
interface pulse_monitor_if #(
  parameter int CBITS  = 15,
  parameter int PCBITS = 8
);
  logic              sig;
  logic              err;
  logic              clr;
  logic              lock;
  logic              fault;
  logic [1:0]        fault_code;
  logic              good;
  logic [PCBITS-1:0] pulse_cnt;
  logic [CBITS:0]    period_last;

  modport master (
    output sig, err, clr,
    input  lock, fault, fault_code, good, pulse_cnt, period_last
  );

  modport slave (
    input  sig, err, clr,
    output lock, fault, fault_code, good, pulse_cnt, period_last
  );
endinterface

// File: rtl/pulse_monitor.sv
// rtl/pulse_monitor.sv - period checker for the delay-stage pulse train
// Locks after LOCK_CNT in-tolerance intervals and latches EARLY/LATE/ERR faults until cleared.
module pulse_monitor #(
  parameter int N        = 22500,
  parameter int CBITS    = 15,
  parameter int TOL      = 2,
  parameter int LOCK_CNT = 3,
  parameter int PCBITS   = 8
) (
  input  logic            clk,
  input  logic            rst,
  pulse_monitor_if.slave  mon
);
  localparam int IW = CBITS + 1;
  localparam int P  = N + 1;
  localparam int RW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [IW-1:0] LO = IW'(P - TOL);
  localparam logic [IW-1:0] HI = IW'(P + TOL);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, FAULT} state_t;

  state_t            state;
  logic [IW-1:0]     ivl;
  logic [RW-1:0]     run;
  logic              lock_q;
  logic              fault_q;
  logic [1:0]        code_q;
  logic              good_q;
  logic [PCBITS-1:0] cnt_q;
  logic [IW-1:0]     plast_q;

  logic is_good;
  logic is_early;
  logic is_late;

  // ivl is the count since the previous sig, so it is judged before reload
  assign is_good  = mon.sig && (ivl >= LO) && (ivl <= HI);
  assign is_early = mon.sig && (ivl < LO);
  assign is_late  = !mon.sig && (ivl > HI);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ivl     <= '0;
      run     <= '0;
      lock_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      good_q  <= 1'b0;
      cnt_q   <= '0;
      plast_q <= '0;
    end else begin
      good_q <= 1'b0;
      if (mon.sig)
        ivl <= IW'(1);
      else if (ivl != '1)
        ivl <= ivl + 1'b1;

      case (state)
        IDLE: begin
          if (mon.sig) begin
            state <= ARMED;
            run   <= '0;
          end
        end
        ARMED: begin
          if (mon.sig)
            plast_q <= ivl;
          if (mon.err) begin
            state   <= FAULT;
            fault_q <= 1'b1;
            code_q  <= 2'b11;
          end else if (is_good) begin
            good_q <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            if (int'(run) + 1 >= LOCK_CNT) begin
              state  <= LOCKED;
              lock_q <= 1'b1;
              run    <= '0;
            end else begin
              run <= run + 1'b1;
            end
          end else if (is_early) begin
            run <= '0;
          end else if (is_late) begin
            state <= IDLE;
            run   <= '0;
          end
        end
        LOCKED: begin
          if (mon.sig)
            plast_q <= ivl;
          if (mon.err || is_early || is_late) begin
            state   <= FAULT;
            lock_q  <= 1'b0;
            fault_q <= 1'b1;
            code_q  <= mon.err ? 2'b11 : (is_early ? 2'b01 : 2'b10);
          end else if (is_good) begin
            good_q <= 1'b1;
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        FAULT: begin
          if (mon.clr) begin
            state   <= IDLE;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mon.lock        = lock_q;
  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.good        = good_q;
  assign mon.pulse_cnt   = cnt_q;
  assign mon.period_last = plast_q;
endmodule

// File: tb/tb_pulse_monitor.sv
// tb/tb_pulse_monitor.sv - scoreboard bench for pulse_monitor
// Stimulus pushes per-cycle expectations from a timestamp-based model; a monitor pops and compares.
module tb_pulse_monitor;
  localparam int N = 8, CBITS = 4, TOL = 1, LOCK_CNT = 3, PCBITS = 4;
  localparam int P = N + 1;
  localparam int SAT = (1 << (CBITS + 1)) - 1;

  typedef struct packed {
    logic       lock;
    logic       fault;
    logic [1:0] code;
    logic       good;
    logic [3:0] cnt;
    logic [4:0] plast;
  } obs_t;

  typedef enum {M_IDLE, M_ARMED, M_LOCKED, M_FAULT} mstate_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pulse_monitor_if #(.CBITS(CBITS), .PCBITS(PCBITS)) bus ();

  pulse_monitor #(
    .N(N), .CBITS(CBITS), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .PCBITS(PCBITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(bus)
  );

  obs_t    expq[$];
  bit      done = 1'b0;
  int      n_cmp = 0;
  int      n_bad = 0;

  mstate_t ms = M_IDLE;
  longint  k = 0;
  longint  ref_t = 0;
  int      run_m = 0;
  obs_t    e_m = '0;

  // Model: interval = cycles since last sig (or since reset), judged by spec bands
  task automatic model(input bit r, input bit s, input bit e, input bit c);
    int iv;
    bit g, ea, la;
    if (r) begin
      ms = M_IDLE; run_m = 0; e_m = '0; ref_t = k + 1;
    end else begin
      iv = int'(k - ref_t);
      if (iv > SAT) iv = SAT;
      g  = s && iv >= P - TOL && iv <= P + TOL;
      ea = s && iv < P - TOL;
      la = !s && iv > P + TOL;
      e_m.good = 1'b0;
      case (ms)
        M_IDLE: if (s) begin ms = M_ARMED; run_m = 0; end
        M_ARMED: begin
          if (s) e_m.plast = 5'(iv);
          if (e) begin ms = M_FAULT; e_m.code = 2'd3; end
          else if (g) begin
            e_m.good = 1'b1; e_m.cnt = 4'((e_m.cnt + 1) % 16); run_m++;
            if (run_m == LOCK_CNT) begin ms = M_LOCKED; run_m = 0; end
          end else if (ea) run_m = 0;
          else if (la) begin ms = M_IDLE; run_m = 0; end
        end
        M_LOCKED: begin
          if (s) e_m.plast = 5'(iv);
          if (e)       begin ms = M_FAULT; e_m.code = 2'd3; end
          else if (ea) begin ms = M_FAULT; e_m.code = 2'd1; end
          else if (la) begin ms = M_FAULT; e_m.code = 2'd2; end
          else if (g)  begin e_m.good = 1'b1; e_m.cnt = 4'((e_m.cnt + 1) % 16); end
        end
        M_FAULT: if (c) begin ms = M_IDLE; e_m.code = 2'd0; end
        default: ms = M_IDLE;
      endcase
      if (s) ref_t = k;
    end
    e_m.lock  = (ms == M_LOCKED);
    e_m.fault = (ms == M_FAULT);
    k++;
  endtask

  task automatic cyc(input bit r, input bit s, input bit e, input bit c);
    @(negedge clk);
    rst = r; bus.sig = s; bus.err = e; bus.clr = c;
    model(r, s, e, c);
    expq.push_back(e_m);
  endtask

  // g cycles ending in a sig; optional err at cycle epos and clr on the first cycle
  task automatic gap(input int g, input int epos, input bit c0);
    for (int i = 0; i < g; i++)
      cyc(1'b0, i == g - 1, i == epos, c0 && i == 0);
  endtask

  task automatic relock();
    gap(3, -1, 1'b0);
    for (int i = 0; i < 3; i++) gap(P, -1, 1'b0);
  endtask

  initial begin
    int r;
    rst = 1'b1; bus.sig = 1'b0; bus.err = 1'b0; bus.clr = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    relock();
    gap(P - 2, -1, 1'b0);
    gap(4, -1, 1'b1);
    relock();
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    gap(3, -1, 1'b1);
    relock();
    gap(P - 2, P - 3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    relock();
    for (int i = 0; i < 16; i++) gap(P, -1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int seg = 0; seg < 300; seg++) begin
      bit c0;
      c0 = (ms == M_FAULT) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 99);
      if (r < 70)      gap($urandom_range(P - TOL, P + TOL), -1, c0);
      else if (r < 82) gap($urandom_range(2, P - TOL - 1), -1, c0);
      else if (r < 90) gap($urandom_range(P + TOL + 2, P + TOL + 5), -1, c0);
      else if (r < 96) begin
        int g;
        g = $urandom_range(P - TOL - 2, P + TOL);
        gap(g, $urandom_range(0, g - 1), c0);
      end else begin
        cyc(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        gap($urandom_range(2, P + TOL), -1, 1'b0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

  initial begin
    obs_t act, exp_v;
    int   idle_cycles = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        act = '{bus.lock, bus.fault, bus.fault_code, bus.good, bus.pulse_cnt, bus.period_last};
        n_cmp++;
        if (act !== exp_v) begin
          n_bad++;
          $display("FAIL outputs t=%0t act lock=%b fault=%b code=%b good=%b cnt=%0d plast=%0d exp lock=%b fault=%b code=%b good=%b cnt=%0d plast=%0d",
                   $time, act.lock, act.fault, act.code, act.good, act.cnt, act.plast,
                   exp_v.lock, exp_v.fault, exp_v.code, exp_v.good, exp_v.cnt, exp_v.plast);
        end
      end else if (done) begin
        break;
      end else begin
        idle_cycles++;
        if (idle_cycles > 50000) begin
          n_bad++;
          $display("FAIL timeout act=no_stimulus_progress exp=done");
          break;
        end
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pulse_monitor.md
PULSE_MONITOR -- requirements
Module: pulse_monitor

Interface
REQ-001 SHALL provide parameter N, default 22500: the upstream delay stage's terminal count; expected pulse period P = N+1 cycles.
REQ-002 SHALL provide parameter CBITS, default 15: upstream counter width; interval counter width is CBITS+1.
REQ-003 SHALL provide parameter TOL, default 2: allowed period deviation in cycles, either direction.
REQ-004 SHALL provide parameter LOCK_CNT, default 3: consecutive good intervals required to lock.
REQ-005 SHALL provide parameter PCBITS, default 8: width of the good-pulse counter.
REQ-006 clk  input  1  sole clock; all state updates on posedge clk.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 sig  input  1  one-cycle period pulse from the upstream delay stage.
REQ-009 err  input  1  upstream overrun error flag.
REQ-010 clr  input  1  fault clear request.
REQ-011 lock  output  1  high while in LOCKED.
REQ-012 fault  output  1  high while in FAULT.
REQ-013 fault_code  output  2  00 none, 01 EARLY, 10 LATE, 11 ERR.
REQ-014 good  output  1  one-cycle pulse on each good interval.
REQ-015 pulse_cnt  output  PCBITS  count of good intervals.
REQ-016 period_last  output  CBITS+1  last measured interval.

Function
REQ-017 Interval counter ivl SHALL load 1 on any cycle with sig=1, else increment, saturating at all-ones; at a sig cycle ivl equals cycles since the previous sig.
REQ-018 Interval SHALL be good when P-TOL <= ivl <= P+TOL, early when ivl < P-TOL, late when ivl > P+TOL with sig=0.
REQ-019 FSM states SHALL be IDLE, ARMED, LOCKED, FAULT; all outputs registered, effective the cycle after the deciding event.
REQ-020 IDLE: sig -> ARMED, run counter cleared; err ignored.
REQ-021 ARMED: good sig -> run+1, and when run reaches LOCK_CNT -> LOCKED; early sig -> stay ARMED, run=0; late -> IDLE, run=0; err -> FAULT, code ERR.
REQ-022 LOCKED: good sig -> stay; err -> FAULT ERR; early sig -> FAULT EARLY; late -> FAULT LATE.
REQ-023 Fault priority on the same cycle SHALL be ERR > EARLY > LATE.
REQ-024 FAULT: state and fault_code held; sig, err ignored; clr -> IDLE with fault_code 00; clr outside FAULT has no effect.
REQ-025 On every good sig in ARMED or LOCKED: good pulses 1 cycle, pulse_cnt increments modulo 2^PCBITS (wraps to 0 from all-ones).
REQ-026 period_last SHALL capture ivl on every sig seen in ARMED or LOCKED, good or not, and hold in FAULT.
REQ-027 The first sig from IDLE SHALL not be judged, counted, or captured.

Reset
REQ-028 rst=1 SHALL, on the next edge, force IDLE, ivl=0, run=0, and all outputs 0, overriding sig, err, clr, including mid-LOCKED or in FAULT.

Verification (N=8 so P=9, TOL=1, LOCK_CNT=3, PCBITS=4)
REQ-029 Assert rst 2 cycles with sig toggling -> lock=fault=good=0, fault_code=00, pulse_cnt=0, period_last=0.
REQ-030 sig every 9 cycles -> good pulses after pulses 2,3,4; lock=1 the cycle after the 4th sig; period_last=9; pulse_cnt=3.
REQ-031 LOCKED, next sig after 7 cycles -> fault=1, lock=0, fault_code=01, period_last=7, pulse_cnt unchanged.
REQ-032 LOCKED, sig withheld -> when ivl reaches 11 with sig=0, fault=1 and fault_code=10 on the next cycle.
REQ-033 LOCKED, err=1 together with an early sig -> fault_code=11; then clr=1 -> IDLE next cycle, fault=0, code=00; 4 more good sigs relock.
REQ-034 18 good intervals -> pulse_cnt wraps 15 -> 0 -> 1 -> 2; rst mid-LOCKED -> all outputs 0 the next cycle.
